// File: rtl/cost_loader_if.sv
// Bundle between the cost-table loader, its upstream stream source and the downstream engine.
// Checksum is present only when COST_CHKSUM_EN is defined.
interface cost_loader_if;
    logic        in_valid;
    logic [6:0]  in_data;
    logic        in_ready;
    logic        reload;
    logic [2:0]  W;
    logic [2:0]  J;
    logic [6:0]  Cost;
    logic        jam_rst;
    logic        load_done;
`ifdef COST_CHKSUM_EN
    logic [12:0] Checksum;

    modport slave  (input  in_valid, in_data, reload, W, J,
                    output in_ready, Cost, jam_rst, load_done, Checksum);
    modport master (output in_valid, in_data, reload, W, J,
                    input  in_ready, Cost, jam_rst, load_done, Checksum);
`else
    modport slave  (input  in_valid, in_data, reload, W, J,
                    output in_ready, Cost, jam_rst, load_done);
    modport master (output in_valid, in_data, reload, W, J,
                    input  in_ready, Cost, jam_rst, load_done);
`endif
endinterface

// File: rtl/cost_loader.sv
// Loads an 8x8 table of 7-bit costs row-major, holds the downstream engine in reset until done.
// Optional running sum of loaded entries on Checksum when COST_CHKSUM_EN is defined.
module cost_loader (
    input  logic         CLK,
    input  logic         RST_N,
    cost_loader_if.slave bus
);
    localparam logic [1:0] LOAD    = 2'd0;
    localparam logic [1:0] RELEASE = 2'd1;
    localparam logic [1:0] RUN     = 2'd2;

    logic [1:0] state;
    logic [5:0] idx;
    logic [6:0] cost_mem [8][8];
    logic       accept;

    assign accept = bus.in_valid && (state == LOAD);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= LOAD;
            idx   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        idx <= idx + 6'd1;
                        if (idx == 6'd63)
                            state <= RELEASE;
                    end
                end
                RELEASE: state <= bus.reload ? LOAD : RUN;
                RUN: begin
                    if (bus.reload) begin
                        state <= LOAD;
                        idx   <= '0;
                    end
                end
                default: begin
                    state <= LOAD;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Table storage is deliberately not reset; contents only become visible in RUN.
    always_ff @(posedge CLK) begin
        if (accept)
            cost_mem[idx[5:3]][idx[2:0]] <= bus.in_data;
    end

    always_comb begin
        bus.in_ready  = (state == LOAD);
        bus.jam_rst   = (state != RUN);
        bus.load_done = (state == RUN);
        bus.Cost      = '0;
        if (state == RUN)
            bus.Cost = cost_mem[bus.W][bus.J];
    end

`ifdef COST_CHKSUM_EN
    logic [12:0] checksum;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            checksum <= '0;
        else if (accept)
            checksum <= checksum + {6'd0, bus.in_data};
        else if ((state != LOAD) && bus.reload)
            checksum <= '0;
    end

    assign bus.Checksum = checksum;
`endif
endmodule

// File: tb/tb_cost_loader.sv
// Directed and randomized check of cost_loader against a flat-array model of the 64-entry table.
// Checksum checks are compiled in when COST_CHKSUM_EN is defined.
module tb_cost_loader;
    logic CLK;
    logic RST_N;
    int   tests;
    int   fails;

    logic [6:0] vals  [64];
    logic [6:0] model [64];

    cost_loader_if bus ();

    cost_loader dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic int sum_vals();
        int s = 0;
        for (int i = 0; i < 64; i++) s += int'(vals[i]);
        return s;
    endfunction

    task automatic check_table(input string tag);
        for (int w = 0; w < 8; w++) begin
            for (int j = 0; j < 8; j++) begin
                bus.W = 3'(w);
                bus.J = 3'(j);
                #1;
                check(tag, 32'(bus.Cost), 32'(model[w*8 + j]));
            end
        end
    endtask

    // mode 0: back-to-back, 1: every other cycle, 2: random gaps with random reload noise
    task automatic load_table(input int n, input int mode, input bit rel_reload);
        int acc = 0;
        int cyc = 0;
        bit v;
        while (acc < n && cyc < 2000) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            bus.in_valid = v;
            bus.in_data  = vals[acc];
            bus.W        = 3'($urandom);
            bus.J        = 3'($urandom);
            bus.reload   = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            check("load_ready", 32'(bus.in_ready), 32'd1);
            check("load_jam", 32'(bus.jam_rst), 32'd1);
            check("load_done_low", 32'(bus.load_done), 32'd0);
            check("load_cost_zero", 32'(bus.Cost), 32'd0);
            step();
            if (v) acc++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.reload   = 1'b0;
        check("load_accepts", 32'(acc), 32'(n));
        if (n == 64) begin
            check("rel_ready", 32'(bus.in_ready), 32'd0);
            check("rel_jam", 32'(bus.jam_rst), 32'd1);
            check("rel_done", 32'(bus.load_done), 32'd0);
            check("rel_cost", 32'(bus.Cost), 32'd0);
`ifdef COST_CHKSUM_EN
            check("rel_chksum", 32'(bus.Checksum), 32'(sum_vals()));
`endif
            if (rel_reload) begin
                bus.reload = 1'b1;
                step();
                bus.reload = 1'b0;
                check("relreload_ready", 32'(bus.in_ready), 32'd1);
                check("relreload_jam", 32'(bus.jam_rst), 32'd1);
                check("relreload_done", 32'(bus.load_done), 32'd0);
`ifdef COST_CHKSUM_EN
                check("relreload_chksum", 32'(bus.Checksum), 32'd0);
`endif
            end else begin
                step();
                check("run_ready", 32'(bus.in_ready), 32'd0);
                check("run_jam", 32'(bus.jam_rst), 32'd0);
                check("run_done", 32'(bus.load_done), 32'd1);
`ifdef COST_CHKSUM_EN
                check("run_chksum", 32'(bus.Checksum), 32'(sum_vals()));
`endif
                for (int i = 0; i < 64; i++) model[i] = vals[i];
            end
        end
    endtask

    task automatic do_reload();
        bus.reload = 1'b1;
        step();
        bus.reload = 1'b0;
        check("reload_ready", 32'(bus.in_ready), 32'd1);
        check("reload_jam", 32'(bus.jam_rst), 32'd1);
        check("reload_done", 32'(bus.load_done), 32'd0);
        check("reload_cost", 32'(bus.Cost), 32'd0);
`ifdef COST_CHKSUM_EN
        check("reload_chksum", 32'(bus.Checksum), 32'd0);
`endif
    endtask

    initial begin
        tests = 0;
        fails = 0;
        RST_N        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.reload   = 1'b0;
        bus.W        = '0;
        bus.J        = '0;
        #1;
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_jam", 32'(bus.jam_rst), 32'd1);
        check("rst_done", 32'(bus.load_done), 32'd0);
        check("rst_cost", 32'(bus.Cost), 32'd0);
`ifdef COST_CHKSUM_EN
        check("rst_chksum", 32'(bus.Checksum), 32'd0);
`endif
        repeat (2) @(posedge CLK);
        #3 RST_N = 1'b1;
        step();

        for (int i = 0; i < 64; i++) vals[i] = 7'(i % 100);
        load_table(64, 0, 1'b0);
        check_table("b2b_table");
        bus.W = 3'd3;
        bus.J = 3'd5;
        #1;
        check("cost_3_5", 32'(bus.Cost), 32'd29);

        do_reload();
        load_table(64, 1, 1'b0);
        check_table("gapped_table");

        for (int c = 0; c < 10; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 7'd127;
            bus.W        = 3'($urandom);
            bus.J        = 3'($urandom);
            step();
            check("run_ignore_ready", 32'(bus.in_ready), 32'd0);
            check("run_ignore_cost", 32'(bus.Cost), 32'(model[{bus.W, bus.J}]));
        end
        bus.in_valid = 1'b0;
        check_table("run_ignore_table");

        do_reload();
        for (int i = 0; i < 64; i++) vals[i] = 7'd1;
        load_table(64, 0, 1'b0);
        check_table("ones_table");
`ifdef COST_CHKSUM_EN
        check("ones_chksum", 32'(bus.Checksum), 32'd64);
`endif

        do_reload();
        for (int i = 0; i < 64; i++) vals[i] = 7'($urandom_range(0, 127));
        load_table(30, 2, 1'b0);
        #2 RST_N = 1'b0;
        #1;
        check("midrst_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_jam", 32'(bus.jam_rst), 32'd1);
        check("midrst_done", 32'(bus.load_done), 32'd0);
`ifdef COST_CHKSUM_EN
        check("midrst_chksum", 32'(bus.Checksum), 32'd0);
`endif
        @(negedge CLK);
        RST_N = 1'b1;
        step();
        for (int i = 0; i < 64; i++) vals[i] = 7'($urandom_range(0, 127));
        load_table(64, 2, 1'b0);
        check_table("after_rst_table");

        do_reload();
        for (int i = 0; i < 64; i++) vals[i] = 7'($urandom_range(0, 127));
        load_table(64, 0, 1'b1);
        for (int i = 0; i < 64; i++) vals[i] = 7'($urandom_range(0, 127));
        load_table(64, 2, 1'b0);
        check_table("rel_reload_table");

        do_reload();
        for (int i = 0; i < 64; i++) vals[i] = 7'd127;
        load_table(64, 0, 1'b0);
        bus.W = 3'd7;
        bus.J = 3'd7;
        #1;
        check("cost_7_7", 32'(bus.Cost), 32'd127);
`ifdef COST_CHKSUM_EN
        check("max_chksum", 32'(bus.Checksum), 32'd8128);
`endif

        for (int r = 0; r < 3; r++) begin
            do_reload();
            for (int i = 0; i < 64; i++) vals[i] = 7'($urandom_range(0, 127));
            load_table(64, 2, 1'b0);
            check_table("rand_table");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
